// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: round-robin grant with burst/lock hold, default-master parking, registered HMASTER/HMASTLOCK.
// Defining AHB_ARB_FIXED_PRIO_EN switches arbitration to fixed priority (lowest index wins).
module ahb_arbiter #(
    parameter  int MASTERS        = 3,
    parameter  int DEFAULT_MASTER = 0,
    localparam int MW             = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
    input  logic               ahb_clk_in,
    input  logic               ahb_rst_in,
    input  logic [MASTERS-1:0] master_req_in,
    input  logic [MASTERS-1:0] master_lock_in,
    input  logic [1:0]         ahb_trans_in,
    input  logic [2:0]         ahb_burst_in,
    input  logic               ahb_ready_in,
    output logic [MASTERS-1:0] master_grant_out,
    output logic [MW-1:0]      master_sel_out,
    output logic               master_lock_out
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_BUSY   = 2'b01;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    logic [MASTERS-1:0] grant_q, grant_d;
    logic [MW-1:0]      sel_q;
    logic               lock_q;
    logic [4:0]         cnt_q, cnt_d;
    logic [MW-1:0]      gnt_idx, win_idx;
    logic               allowed;
    logic               unused_burst;

    // HBURST[0] only distinguishes wrapping from incrementing, which does not affect beat count.
    assign unused_burst = ahb_burst_in[0];

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < MASTERS; i++) begin
            if (grant_q[i]) gnt_idx = MW'(i);
        end
    end

    // A locked holder that still requests keeps the bus even at burst end.
    assign allowed = (cnt_q <= 5'd1) &&
                     !(master_lock_in[gnt_idx] && master_req_in[gnt_idx]);

`ifdef AHB_ARB_FIXED_PRIO_EN
    always_comb begin
        win_idx = MW'(DEFAULT_MASTER);
        for (int i = MASTERS - 1; i >= 0; i--) begin
            if (master_req_in[i]) win_idx = MW'(i);
        end
    end

    always_comb begin
        grant_d = grant_q;
        if (allowed) begin
            grant_d = (|master_req_in) ? (MASTERS'(1) << win_idx)
                                       : (MASTERS'(1) << DEFAULT_MASTER);
        end
    end
`else
    logic [MW-1:0] ptr_q, ptr_d;
    logic          found;
    int            idx;

    always_comb begin
        win_idx = MW'(DEFAULT_MASTER);
        found   = 1'b0;
        idx     = 0;
        for (int k = 1; k <= MASTERS; k++) begin
            idx = (int'(ptr_q) + k) % MASTERS;
            if (!found && master_req_in[idx]) begin
                found   = 1'b1;
                win_idx = MW'(idx);
            end
        end
    end

    always_comb begin
        grant_d = grant_q;
        ptr_d   = ptr_q;
        if (allowed) begin
            if (|master_req_in) begin
                grant_d = MASTERS'(1) << win_idx;
                ptr_d   = win_idx;
            end else begin
                grant_d = MASTERS'(1) << DEFAULT_MASTER;
            end
        end
    end

    always_ff @(posedge ahb_clk_in) begin
        if (ahb_rst_in) ptr_q <= MW'(DEFAULT_MASTER);
        else            ptr_q <= ptr_d;
    end
`endif

    always_comb begin
        cnt_d = cnt_q;
        if (ahb_ready_in) begin
            case (ahb_trans_in)
                TRANS_NONSEQ: begin
                    case (ahb_burst_in[2:1])
                        2'b01:   cnt_d = 5'd3;
                        2'b10:   cnt_d = 5'd7;
                        2'b11:   cnt_d = 5'd15;
                        default: cnt_d = 5'd0;
                    endcase
                end
                TRANS_SEQ:  cnt_d = (cnt_q == 5'd0) ? 5'd0 : cnt_q - 5'd1;
                TRANS_BUSY: cnt_d = cnt_q;
                TRANS_IDLE: cnt_d = 5'd0;
                default:    cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge ahb_clk_in) begin
        if (ahb_rst_in) begin
            grant_q <= MASTERS'(1) << DEFAULT_MASTER;
            sel_q   <= MW'(DEFAULT_MASTER);
            lock_q  <= 1'b0;
            cnt_q   <= 5'd0;
        end else begin
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            if (ahb_ready_in) begin
                sel_q  <= gnt_idx;
                lock_q <= master_lock_in[gnt_idx];
            end
        end
    end

    assign master_grant_out = grant_q;
    assign master_sel_out   = sel_q;
    assign master_lock_out  = lock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Bench for ahb_arbiter: hand-derived vector table for the directed scenarios, then random
// stimulus checked against a behavioural model of the arbitration rules.
module tb_ahb_arbiter;

    localparam int M  = 3;
    localparam int DM = 0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] req = '0;
    logic [2:0] lock = '0;
    logic [1:0] trans = '0;
    logic [2:0] burst = '0;
    logic       ready = 1'b1;
    logic [2:0] grant;
    logic [1:0] sel;
    logic       lk;

    int pass_cnt = 0;
    int total_cnt = 0;

    // behavioural model state: granted index, owner, owner lock, remaining beats, rr pointer
    int m_g = DM, m_s = DM, m_k = 0, m_c = 0, m_p = DM;

    always #5 clk = ~clk;

    ahb_arbiter #(.MASTERS(M), .DEFAULT_MASTER(DM)) dut (
        .ahb_clk_in      (clk),
        .ahb_rst_in      (rst),
        .master_req_in   (req),
        .master_lock_in  (lock),
        .ahb_trans_in    (trans),
        .ahb_burst_in    (burst),
        .ahb_ready_in    (ready),
        .master_grant_out(grant),
        .master_sel_out  (sel),
        .master_lock_out (lk)
    );

    typedef struct {
        bit       r;
        bit [2:0] q;
        bit [2:0] l;
        bit [1:0] t;
        bit [2:0] b;
        bit       rd;
        bit [2:0] g;
        bit [1:0] s;
        bit       k;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit r, bit [2:0] q, bit [2:0] l, bit [1:0] t, bit [2:0] b,
                                bit rd, bit [2:0] g, bit [1:0] s, bit k);
        vec_t v;
        v.r = r; v.q = q; v.l = l; v.t = t; v.b = b; v.rd = rd; v.g = g; v.s = s; v.k = k;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_edge();
        int ng, np, nc, b;
        bit allow;
        if (rst) begin
            m_g = DM; m_s = DM; m_k = 0; m_c = 0; m_p = DM;
            return;
        end
        ng = m_g; np = m_p; nc = m_c;
        allow = (m_c <= 1) && !(lock[m_g] && req[m_g]);
        if (ready) begin
            b = int'(burst) / 2;
            case (trans)
                2'b10:   nc = (b == 0) ? 0 : (1 << (b + 1)) - 1;
                2'b11:   nc = (m_c > 0) ? m_c - 1 : 0;
                2'b01:   nc = m_c;
                default: nc = 0;
            endcase
        end
        if (allow) begin
            if (req == 3'b000) ng = DM;
            else begin
`ifdef AHB_ARB_FIXED_PRIO_EN
                for (int i = M - 1; i >= 0; i--) if (req[i]) ng = i;
`else
                for (int k = M; k >= 1; k--) begin
                    if (req[(m_p + k) % M]) begin
                        ng = (m_p + k) % M;
                        np = ng;
                    end
                end
`endif
            end
        end
        if (ready) begin
            m_s = m_g;
            m_k = int'(lock[m_g]);
        end
        m_g = ng; m_p = np; m_c = nc;
    endtask

    task automatic apply(bit r, bit [2:0] q, bit [2:0] l, bit [1:0] t, bit [2:0] b, bit rd);
        @(negedge clk);
        rst = r; req = q; lock = l; trans = t; burst = b; ready = rd;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_model(string tag);
        check({tag, "_grant"}, grant, 32'(1 << m_g));
        check({tag, "_sel"},   sel,   32'(m_s));
        check({tag, "_lock"},  lk,    32'(m_k));
    endtask

    initial begin
        // rst, req, lock, trans, burst, ready -> grant, sel, lock
        tbl.push_back(mk(1, 3'b000, 3'b000, 2'd0, 3'd0, 1, 3'b001, 2'd0, 0));
        tbl.push_back(mk(0, 3'b000, 3'b000, 2'd0, 3'd0, 1, 3'b001, 2'd0, 0));
        tbl.push_back(mk(0, 3'b000, 3'b000, 2'd0, 3'd0, 1, 3'b001, 2'd0, 0));
        // alternation between M1 and M2
        tbl.push_back(mk(0, 3'b110, 3'b000, 2'd2, 3'd0, 1, 3'b010, 2'd0, 0));
        tbl.push_back(mk(0, 3'b110, 3'b000, 2'd2, 3'd0, 1, 3'b100, 2'd1, 0));
        tbl.push_back(mk(0, 3'b110, 3'b000, 2'd2, 3'd0, 1, 3'b010, 2'd2, 0));
        tbl.push_back(mk(0, 3'b110, 3'b000, 2'd2, 3'd0, 1, 3'b100, 2'd1, 0));
        // M1 takes the bus then runs INCR4; M2 starts requesting on beat 2
        tbl.push_back(mk(0, 3'b010, 3'b000, 2'd0, 3'd0, 1, 3'b010, 2'd2, 0));
        tbl.push_back(mk(0, 3'b010, 3'b000, 2'd0, 3'd0, 1, 3'b010, 2'd1, 0));
        tbl.push_back(mk(0, 3'b010, 3'b000, 2'd2, 3'd3, 1, 3'b010, 2'd1, 0));
        tbl.push_back(mk(0, 3'b110, 3'b000, 2'd3, 3'd3, 1, 3'b010, 2'd1, 0));
        tbl.push_back(mk(0, 3'b110, 3'b000, 2'd3, 3'd3, 1, 3'b010, 2'd1, 0));
        tbl.push_back(mk(0, 3'b110, 3'b000, 2'd3, 3'd3, 1, 3'b100, 2'd1, 0));
        tbl.push_back(mk(0, 3'b100, 3'b000, 2'd0, 3'd0, 1, 3'b100, 2'd2, 0));
        // M2 INCR4 with three wait states on beat 2
        tbl.push_back(mk(0, 3'b100, 3'b000, 2'd2, 3'd3, 1, 3'b100, 2'd2, 0));
        tbl.push_back(mk(0, 3'b110, 3'b000, 2'd3, 3'd3, 0, 3'b100, 2'd2, 0));
        tbl.push_back(mk(0, 3'b110, 3'b000, 2'd3, 3'd3, 0, 3'b100, 2'd2, 0));
        tbl.push_back(mk(0, 3'b110, 3'b000, 2'd3, 3'd3, 0, 3'b100, 2'd2, 0));
        tbl.push_back(mk(0, 3'b110, 3'b000, 2'd3, 3'd3, 1, 3'b100, 2'd2, 0));
        tbl.push_back(mk(0, 3'b110, 3'b000, 2'd3, 3'd3, 1, 3'b100, 2'd2, 0));
        tbl.push_back(mk(0, 3'b110, 3'b000, 2'd3, 3'd3, 1, 3'b010, 2'd2, 0));
        tbl.push_back(mk(0, 3'b110, 3'b000, 2'd0, 3'd0, 1, 3'b100, 2'd1, 0));
        // M2 locked with M1 requesting, then lock released
        tbl.push_back(mk(0, 3'b110, 3'b100, 2'd2, 3'd0, 1, 3'b100, 2'd2, 1));
        tbl.push_back(mk(0, 3'b110, 3'b100, 2'd2, 3'd0, 1, 3'b100, 2'd2, 1));
        tbl.push_back(mk(0, 3'b110, 3'b100, 2'd2, 3'd0, 1, 3'b100, 2'd2, 1));
        tbl.push_back(mk(0, 3'b110, 3'b000, 2'd2, 3'd0, 1, 3'b010, 2'd2, 0));
        tbl.push_back(mk(0, 3'b000, 3'b000, 2'd0, 3'd0, 1, 3'b001, 2'd1, 0));
        // reset in the middle of an INCR8 (counter at 5)
        tbl.push_back(mk(0, 3'b010, 3'b000, 2'd0, 3'd0, 1, 3'b010, 2'd0, 0));
        tbl.push_back(mk(0, 3'b010, 3'b000, 2'd2, 3'd5, 1, 3'b010, 2'd1, 0));
        tbl.push_back(mk(0, 3'b110, 3'b000, 2'd3, 3'd5, 1, 3'b010, 2'd1, 0));
        tbl.push_back(mk(0, 3'b110, 3'b000, 2'd3, 3'd5, 1, 3'b010, 2'd1, 0));
        tbl.push_back(mk(1, 3'b110, 3'b000, 2'd3, 3'd5, 1, 3'b001, 2'd0, 0));
        tbl.push_back(mk(0, 3'b110, 3'b000, 2'd3, 3'd5, 1, 3'b010, 2'd0, 0));
        tbl.push_back(mk(0, 3'b000, 3'b000, 2'd0, 3'd0, 1, 3'b001, 2'd1, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].r, tbl[i].q, tbl[i].l, tbl[i].t, tbl[i].b, tbl[i].rd);
`ifdef AHB_ARB_FIXED_PRIO_EN
            check_model($sformatf("vec%0d", i));
`else
            check($sformatf("vec%0d_grant", i), grant, tbl[i].g);
            check($sformatf("vec%0d_sel", i),   sel,   tbl[i].s);
            check($sformatf("vec%0d_lock", i),  lk,    tbl[i].k);
`endif
        end

`ifdef AHB_ARB_FIXED_PRIO_EN
        apply(1, 3'b000, 3'b000, 2'd0, 3'd0, 1);
        for (int i = 0; i < 4; i++) begin
            apply(0, 3'b111, 3'b000, 2'd2, 3'd0, 1);
            check($sformatf("fixed%0d_grant", i), grant, 3'b001);
        end
`endif

        for (int i = 0; i < 1500; i++) begin
            apply($urandom_range(0, 199) == 0, 3'($urandom),
                  ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000,
                  2'($urandom), 3'($urandom), $urandom_range(0, 3) != 0);
            check_model("rnd");
            check("rnd_onehot", 32'($onehot(grant)), 32'd1);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ahb_arbiter.md
Name: ahb_arbiter

Overview:
- Multi-master AHB bus arbiter for the ahb_proto subsystem.
- Grants the shared address/data bus to one of MASTERS requesters. Arbitration is round-robin by default.
- Holds the grant through fixed-length bursts and locked sequences.
- Parks the bus on a default master when nobody requests. Drives the address-phase owner index that steers the master-side address/control mux ahead of ahb_decoder.

Parameters:
- MASTERS, 3, number of requesting masters (2..8)
- DEFAULT_MASTER, 0, parking master index when no requests (0..MASTERS-1)
- MW, $clog2(MASTERS), width of master index (derived localparam, not user-set)

Ports:
- ahb_clk_in  input  1  bus clock, all logic on rising edge
- ahb_rst_in  input  1  synchronous reset, active-high
- master_req_in  input  MASTERS  per-master bus request (HBUSREQx)
- master_lock_in  input  MASTERS  per-master locked-transfer request (HLOCKx)
- ahb_trans_in  input  2  HTRANS of current address-phase owner: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- ahb_burst_in  input  3  HBURST of current owner
- ahb_ready_in  input  1  bus-wide HREADY
- master_grant_out  output  MASTERS  one-hot grant (HGRANTx), registered
- master_sel_out  output  MW  address-phase owner index (HMASTER), registered
- master_lock_out  output  1  owner's transfer is locked (HMASTLOCK), registered

Behaviour:
- Reset (ahb_rst_in=1 at edge):
  - master_grant_out = one-hot DEFAULT_MASTER
  - master_sel_out = DEFAULT_MASTER
  - master_lock_out = 0
  - beat counter = 0
  - round-robin pointer = DEFAULT_MASTER
- Reset asserted mid-burst or mid-lock aborts everything to these values on the same edge.
- Handover:
  - On every edge with ahb_ready_in=1: master_sel_out <= index of master_grant_out, and master_lock_out <= master_lock_in[granted index].
  - With ahb_ready_in=0, both hold.
- Beat counter (5 bits, remaining beats of current fixed burst), updated only on edges with ahb_ready_in=1:
  - NONSEQ: load L-1, where L=4 for HBURST 010/011, L=8 for 100/101, L=16 for 110/111, and L=0 (counter 0) for SINGLE 000 or INCR 001.
  - SEQ: decrement, saturating at 0.
  - BUSY: hold.
  - IDLE: clear to 0 (early burst termination).
- Re-arbitration allowed in a cycle when:
  - counter <= 1, i.e. no burst, or the last beat is presently in address phase; and
  - not (master_lock_in[g] & master_req_in[g]), where g = granted index.
- Arbitration, when allowed; the grant register updates on that edge regardless of ahb_ready_in:
  - Search master_req_in starting at pointer+1, wrapping modulo MASTERS.
  - First requester found is granted; pointer <= its index.
  - Current holder still requesting and no other requester: keep grant.
  - No requests: grant DEFAULT_MASTER; pointer unchanged.
- When re-arbitration is not allowed, grant holds, even if the holder drops its request.
- Latency:
  - Request to grant: 1 cycle when arbitration is allowed.
  - Grant to owner: the first subsequent edge with ahb_ready_in=1.
- master_grant_out is always exactly one-hot; never all-zero.
- Simultaneous events:
  - Lock wins over burst-end re-arbitration.
  - Counter load and grant change on the same edge are both taken; the counter tracks the bus, not the grantee.

Optional Feature:
- Macro: AHB_ARB_FIXED_PRIO_EN
- Defined: arbitration is fixed priority, lowest index wins, and the pointer is unused. Burst/lock hold rules, parking and handover are unchanged.
- Undefined: round-robin as above.

Test Plan:
- Reset, no requests, ahb_ready_in=1 -> grant=3'b001, master_sel_out=0, master_lock_out=0; parked indefinitely.
- master_req_in=3'b110 constant, trans=NONSEQ burst=SINGLE every cycle, ready=1 -> grants alternate 3'b010, 3'b100, 3'b010 each cycle; master_sel_out follows grant one cycle later.
- M1 granted issues NONSEQ INCR4 plus 3 SEQ with M2 requesting, ready=1 -> grant stays 3'b010 until the cycle the 4th beat is in address phase, then 3'b100 next edge; master_sel_out=2 on the following edge.
- Same INCR4 with ahb_ready_in=0 for 3 cycles on beat 2 -> counter and master_sel_out hold; handover delayed exactly 3 cycles.
- M2 asserts master_lock_in and master_req_in, M1 requesting, bursts SINGLE -> grant stays 3'b100 and master_lock_out=1 while lock held; lock drop -> grant 3'b010 next edge, master_lock_out=0 on next ready edge.
- Reset pulsed mid-INCR8 (counter=5) -> next cycle grant=3'b001, counter=0, master_sel_out=0. With AHB_ARB_FIXED_PRIO_EN, master_req_in=3'b111 -> M0 granted every arbitration.
